key_event: RTL
==============

KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL have parameter LONG_CYC, default 1000: high samples that qualify a long press (>=2).
REQ-002 SHALL have parameter GAP_CYC, default 200: low samples that close the double-click window (>=2).
REQ-003 SHALL have parameter REP_CYC, default 100: auto-repeat period while held (>=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port key_in  input  1  debounced active-high key level, synchronous to clk.
REQ-007 SHALL have port short_press  output  1  one-cycle pulse, single short click.
REQ-008 SHALL have port double_click  output  1  one-cycle pulse, two clicks within the gap window.
REQ-009 SHALL have port long_press  output  1  one-cycle pulse at long-press qualification.
REQ-010 SHALL have port repeat  output  1  one-cycle pulse every REP_CYC cycles while a long press is held.
REQ-011 SHALL have port hold  output  1  level, high while in LONG.

Function
REQ-012 SHALL register key_in into key_d; rise = key_in & ~key_d, fall = ~key_in & key_d, evaluated at each clock edge.
REQ-013 SHALL use states IDLE, PRESS1, WAIT2, PRESS2, LONG, plus one counter of width clog2(max(LONG_CYC,GAP_CYC,REP_CYC))+1.
REQ-014 IDLE: rise -> PRESS1, counter=1; otherwise stay.
REQ-015 PRESS1: while key_in=1, counter increments; when key_in=1 and counter==LONG_CYC-1 -> LONG, long_press pulse, counter=0.
REQ-016 PRESS1: key_in=0 before qualification -> WAIT2, counter=1.
REQ-017 WAIT2: key_in=0 and counter==GAP_CYC-1 -> IDLE, short_press pulse; key_in=1 (rise) before that -> PRESS2.
REQ-018 PRESS2: key_in=0 -> IDLE, double_click pulse, independent of second-press length.
REQ-019 LONG: hold=1; counter increments per cycle; counter==REP_CYC-1 -> repeat pulse, counter=0.
REQ-020 LONG: key_in=0 -> IDLE, hold drops the following cycle, no short_press/double_click emitted.
REQ-021 All outputs SHALL be registered; a pulse is high exactly one cycle, in the cycle after the deciding edge.
REQ-022 At most one of short_press, double_click, long_press SHALL be high in any cycle; repeat never coincides with long_press.
REQ-023 Boundary: LONG_CYC-1 high samples then low -> short path; exactly LONG_CYC high samples -> long_press.
REQ-024 Boundary: exactly GAP_CYC low samples -> short_press; rise on sample GAP_CYC-1 or earlier -> PRESS2.
REQ-025 Counter SHALL saturate-free by construction (every state clears it before overflow); no wrap-around events.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, counter=0, all outputs 0, key_d=1.
REQ-027 A key held high through reset release SHALL produce no event until released and pressed again.
REQ-028 Reset asserted mid-press or mid-window SHALL discard the pending event with no pulse.

Structure
REQ-029 State encodings and default parameter values SHALL live in a shared constants include used by key_event and its bench.
REQ-030 Edge detection (key_d register, rise/fall) SHALL be a sub-module edge_detect; FSM, counter and output registers stay in key_event.

Verification (LONG_CYC=8, GAP_CYC=4, REP_CYC=3)
REQ-031 key high 3 cycles, then low 6 -> short_press once, 4 cycles after fall, no other pulse.
REQ-032 high 2, low 2, high 2, low -> double_click once, cycle after second fall; no short_press.
REQ-033 high 7 then low -> short path (short_press after gap); high 8 -> long_press cycle after 8th sample, hold=1.
REQ-034 high 20 -> long_press at 8, repeat at +3,+6,+9,+12 relative, hold falls one cycle after release, no click pulses.
REQ-035 key high during rst_n low then released; hold key 20 cycles -> no outputs; release, press 3 -> short_press.
REQ-036 rst_n pulsed low during WAIT2 -> no short_press, state IDLE, all outputs 0 immediately.

Source files
------------

// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - shared state encoding, default timing and counter sizing for key_event
package key_event_pkg;

    localparam int LONG_CYC_DEF = 1000;
    localparam int GAP_CYC_DEF  = 200;
    localparam int REP_CYC_DEF  = 100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/key_event_edge.sv
// rtl/key_event_edge.sv - one-sample key delay with rise/fall detection
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic rise,
    output logic fall
);

    logic key_dly_q;
    logic key_dly_d;

    always_comb begin
        key_dly_d = key_in;
    end

    // Delay resets high so a key held through reset never looks like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_dly_q <= 1'b1;
        end else begin
            key_dly_q <= key_dly_d;
        end
    end

    assign rise = key_in & ~key_dly_q;
    assign fall = ~key_in & key_dly_q;

endmodule

// File: rtl/key_event.sv
// rtl/key_event.sv - key gesture decoder: short click, double click, long press with auto-repeat
module key_event
    import key_event_pkg::*;
#(
    parameter int LONG_CYC = LONG_CYC_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF,
    parameter int REP_CYC  = REP_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic hold
);

    localparam int CW = cnt_width(LONG_CYC, GAP_CYC, REP_CYC);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic rise;
    logic fall;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          short_q, short_d;
    logic          dbl_q, dbl_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          hold_q, hold_d;

    edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                    cnt_d   = CNT_ONE;
                end
            end
            // The key was high last sample here, so fall is exactly "key now low".
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_WAIT2;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT2: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    dbl_d   = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REP_LAST) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        hold_d = (state_d == ST_LONG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            dbl_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            dbl_q   <= dbl_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            hold_q  <= hold_d;
        end
    end

    // The auto-repeat output cannot be called "repeat", which is a reserved word.
    assign short_press  = short_q;
    assign double_click = dbl_q;
    assign long_press   = long_q;
    assign repeat_pulse = rep_q;
    assign hold         = hold_q;

endmodule
